// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the serial-in/parallel-out deserialiser.
// Holds the default word width, shift-direction encodings and counter sizing.
package sipo_pkg;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    typedef enum logic {
        SIPO_LSB_FIRST = 1'b0,
        SIPO_MSB_FIRST = 1'b1
    } sipo_order_e;

    // A 2-bit word still needs a 1-bit counter, so clamp the result to at least 1.
    function automatic int sipo_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Modulo-WIDTH bit counter that advances on each enabled edge.
// o_wrap is high while enabled on the count that completes a word.
module sipo_bitcnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEFAULT_WIDTH,
    parameter int CW    = sipo_cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_wrap
);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CW'(WIDTH - 1));
    assign o_wrap = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_1.sv
// Serial-in/parallel-out shift register with load qualification and a
// registered one-cycle frame_done strobe per completed WIDTH-bit word.
module sipo_1
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_done
);

    logic [WIDTH-1:0] r_data;
    logic             r_frame_done;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Direction decides which end the new bit enters; the first bit ends at the far end.
    if (sipo_order_e'(MSB_FIRST) == SIPO_MSB_FIRST) begin : g_msb_first
        assign w_next = {r_data[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
        assign w_next = {data_in, r_data[WIDTH-1:1]};
    end

    sipo_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .rst    (rst),
        .i_en   (load),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (load) begin
                r_data <= w_next;
            end
        end
    end

    assign data_out   = r_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sipo_1.sv
// Directed bench for sipo_1: an MSB-first and an LSB-first instance share
// the same serial stream, checked with immediate assertions.
module tb_sipo_1;

    logic       clk;
    logic       rst;
    logic       load;
    logic       data_in;
    logic [7:0] data_m;
    logic [7:0] data_l;
    logic       fd_m;
    logic       fd_l;

    int checks = 0;
    int errors = 0;

    int cyc      = 0;
    int fd_cnt_m = 0;
    int fd_cnt_l = 0;
    int fd_last  = 0;
    int fd_prev  = 0;

    sipo_1 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .data_out   (data_m),
        .frame_done (fd_m)
    );

    sipo_1 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data_in    (data_in),
        .data_out   (data_l),
        .frame_done (fd_l)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts strobes and remembers when the last two occurred.
    always @(negedge clk) begin
        if (fd_m === 1'b1) begin
            fd_cnt_m = fd_cnt_m + 1;
            fd_prev  = fd_last;
            fd_last  = cyc;
        end
        if (fd_l === 1'b1) fd_cnt_l = fd_cnt_l + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        load    = 1'b1;
        data_in = b;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            load    = 1'b0;
            data_in = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    logic [7:0] exp_m;
    logic [7:0] exp_l;
    logic [7:0] pat;
    int         base_m;
    int         base_l;

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset: scramble state, then assert rst between edges.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_bit(1'($urandom_range(0, 1)));
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_m", data_m, 8'h00);
        chk("async_rst_data_l", data_l, 8'h00);
        chk("async_rst_fd", {6'd0, fd_l, fd_m}, 8'h00);
        tick();
        rst = 1'b0;
        idle(4);
        chk("idle_after_rst_m", data_m, 8'h00);
        chk("idle_after_rst_l", data_l, 8'h00);

        // Word 1: 1,1,1,1,0,0,0,0
        base_m = fd_cnt_m;
        base_l = fd_cnt_l;
        pat = 8'hF0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i != 0) chk("w1_no_fd", {7'd0, fd_m}, 8'h00);
        end
        chk("w1_data_m", data_m, 8'hF0);
        chk("w1_data_l", data_l, 8'h0F);
        chk("w1_fd_m", {7'd0, fd_m}, 8'h01);
        chk("w1_fd_l", {7'd0, fd_l}, 8'h01);
        idle(1);
        chk("w1_fd_one_cycle", {7'd0, fd_m}, 8'h00);
        idle(3);
        chk("w1_hold_m", data_m, 8'hF0);
        chk("w1_hold_l", data_l, 8'h0F);
        chk("w1_pulses_m", 8'(fd_cnt_m - base_m), 8'd1);
        chk("w1_pulses_l", 8'(fd_cnt_l - base_l), 8'd1);

        // Word 2: 1,0,1,0,1,0,1,0
        base_m = fd_cnt_m;
        pat = 8'hAA;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        chk("w2_data_m", data_m, 8'hAA);
        chk("w2_data_l", data_l, 8'h55);
        idle(2);
        chk("w2_pulses_m", 8'(fd_cnt_m - base_m), 8'd1);

        // Word 3: eight 1s from a cleared register, every intermediate value checked.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_m = 8'h00;
        exp_l = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            exp_m = (exp_m << 1) | 8'h01;
            exp_l = (exp_l >> 1) | 8'h80;
            chk("w3_step_m", data_m, exp_m);
            chk("w3_step_l", data_l, exp_l);
            chk("w3_fd", {7'd0, fd_m}, (i == 7) ? 8'h01 : 8'h00);
        end
        chk("w3_final_m", data_m, 8'hFF);
        idle(2);

        // Gap: 1,1,0,0 | three idle cycles | 1,0,0,1
        base_m = fd_cnt_m;
        pat = 8'hC9;
        for (int i = 7; i >= 4; i--) send_bit(pat[i]);
        chk("gap_mid_fd", {7'd0, fd_m}, 8'h00);
        idle(3);
        chk("gap_hold_fd", {7'd0, fd_m}, 8'h00);
        for (int i = 3; i >= 1; i--) send_bit(pat[i]);
        chk("gap_bit7_fd", {7'd0, fd_m}, 8'h00);
        send_bit(pat[0]);
        chk("gap_data_m", data_m, 8'hC9);
        chk("gap_data_l", data_l, 8'h93);
        chk("gap_fd", {7'd0, fd_m}, 8'h01);
        idle(2);
        chk("gap_pulses", 8'(fd_cnt_m - base_m), 8'd1);

        // Back-to-back: 0x12 then 0xB4 with load held high throughout.
        base_m = fd_cnt_m;
        pat = 8'h12;
        for (int i = 7; i >= 0; i--) send_bit(pat[i]);
        chk("b2b_w1_m", data_m, 8'h12);
        chk("b2b_w1_l", data_l, 8'h48);
        chk("b2b_w1_fd", {7'd0, fd_m}, 8'h01);
        pat = 8'hB4;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 7) chk("b2b_fd_drop", {7'd0, fd_m}, 8'h00);
        end
        chk("b2b_w2_m", data_m, 8'hB4);
        chk("b2b_w2_l", data_l, 8'h2D);
        chk("b2b_w2_fd", {7'd0, fd_l}, 8'h01);
        idle(2);
        chk("b2b_pulses", 8'(fd_cnt_m - base_m), 8'd2);
        chk("b2b_spacing", 8'(fd_last - fd_prev), 8'd8);

        // Reset mid-word: 5 bits, reset, then a fresh 0x3C.
        base_m = fd_cnt_m;
        pat = 8'hB0;
        for (int i = 7; i >= 3; i--) send_bit(pat[i]);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_data_m", data_m, 8'h00);
        chk("midrst_data_l", data_l, 8'h00);
        tick();
        rst = 1'b0;
        pat = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            chk("midrst_fd", {7'd0, fd_m}, (i == 0) ? 8'h01 : 8'h00);
        end
        chk("midrst_data_m", data_m, 8'h3C);
        chk("midrst_data_l", data_l, 8'h3C);
        idle(2);
        chk("midrst_pulses", 8'(fd_cnt_m - base_m), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_1.md
Name: sipo_1

Overview:
- Serial-in, parallel-out shift register with load (shift-enable) qualification.
- When `load` is high, one serial bit is captured per rising clock edge. The accumulated word is presented continuously on `data_out`.
- A one-cycle `frame_done` strobe flags each completed WIDTH-bit word.
- Used as a deserialiser front end between a serial link and word-wide logic.

Parameters:
- WIDTH, 8, parallel word width in bits (≥2).
- MSB_FIRST, 1, 1 = first received bit ends at `data_out[WIDTH-1]` (shift toward MSB); 0 = first received bit ends at `data_out[0]` (shift toward LSB).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-high.
- load  input  1  shift enable; a bit is captured on each rising edge where `load`=1.
- data_in  input  1  serial data bit.
- data_out  output  WIDTH  current shift-register contents, registered.
- frame_done  output  1  one-cycle pulse, registered; asserted in the cycle after the WIDTH-th bit of a word is captured.

Interface: one clock; reset is asynchronous and active-high. Ports are named `clk` and `rst`. Port order is clk, rst, load, data_in, data_out, frame_done. Positional instantiation of the first five ports must remain valid, with `frame_done` left unconnected.

Behaviour:
- Reset (`rst`=1, asynchronous, any time including mid-frame):
  - `data_out` = 0.
  - Bit counter = 0.
  - `frame_done` = 0.
  - Held while `rst`=1; normal operation resumes on the first rising edge after deassertion.
- Shift, `load`=1 at a rising edge:
  - MSB_FIRST=1: `data_out` <= {`data_out`[WIDTH-2:0], `data_in`}.
  - MSB_FIRST=0: `data_out` <= {`data_in`, `data_out`[WIDTH-1:1]}.
- Hold, `load`=0: `data_out` and the bit counter are unchanged.
- Latency: `data_out` reflects a captured bit 1 cycle after the capturing edge. A full word is valid on `data_out` after WIDTH qualified edges.
- Bit counter:
  - Width is clog2(WIDTH) bits; increments on each qualified edge.
  - On the edge capturing bit WIDTH-1 (count = WIDTH-1), the counter wraps to 0 and `frame_done` is set to 1 for exactly one cycle.
  - `frame_done` is 0 on all other edges.
- Gaps: deasserting `load` mid-word does not abort the word. The counter holds and resumes when `load` returns.
- Back-to-back words: continuous `load`=1 produces a `frame_done` pulse every WIDTH cycles with no dead cycle.
- No combinational path from inputs to outputs.
- `data_in` is don't-care when `load`=0.

Decomposition:
- Shared package `sipo_pkg` holds:
  - the default WIDTH constant;
  - the counter width function (clog2);
  - MSB_FIRST enumeration constants.
- Single module; no sub-module needed.
- Optional sub-module `sipo_bitcnt` (modulo-WIDTH counter with wrap strobe) if reuse is desired.

Test Plan:
- Reset: assert `rst` with random state → `data_out`=8'h00, `frame_done`=0 immediately (asynchronously); release and hold `load`=0 for 4 cycles → `data_out` stays 8'h00.
- Word 1: `load`=1 for 8 edges, serial 1,1,1,1,0,0,0,0 then `load`=0 → `data_out`=8'hF0; `frame_done` pulses once after the 8th edge; value holds 3+ idle cycles.
- Word 2: serial 1,0,1,0,1,0,1,0 → `data_out`=8'hAA, one `frame_done`. With MSB_FIRST=0 the same stream → 8'h55.
- Word 3: eight 1s → `data_out`=8'hFF, `frame_done` once; intermediate values 8'h01, 8'h03, … 8'h7F after successive edges.
- Gap and back-to-back:
  - 4 bits, then `load`=0 for 3 cycles, then 4 more bits (1,1,0,0 | 1,0,0,1) → `data_out`=8'hC9 with a single `frame_done` after the 8th bit.
  - 16 continuous bits → two `frame_done` pulses exactly 8 cycles apart.
- Reset mid-word: assert `rst` after 5 bits → `data_out`=0; after release, 8 new bits 0x3C → `data_out`=8'h3C, and `frame_done` occurs only after all 8 new bits (counter was cleared).
